// File: rtl/cr16_psr_pkg.sv
// Shared CR16 definitions: status bit positions, ALU opcodes and condition codes.
// Used by the ALU, the decoder and the status register.
package cr16_psr_pkg;

  localparam int unsigned FlagW = 5;

  // Status / flag bit positions
  localparam int unsigned FlagC = 0;
  localparam int unsigned FlagL = 1;
  localparam int unsigned FlagF = 2;
  localparam int unsigned FlagZ = 3;
  localparam int unsigned FlagN = 4;

  // ALU opcodes; 14 and 15 are reserved and never write flags
  localparam logic [3:0] OpAdd   = 4'd0;
  localparam logic [3:0] OpAddu  = 4'd1;
  localparam logic [3:0] OpAddc  = 4'd2;
  localparam logic [3:0] OpAddcu = 4'd3;
  localparam logic [3:0] OpSub   = 4'd4;
  localparam logic [3:0] OpSubu  = 4'd5;
  localparam logic [3:0] OpAnd   = 4'd6;
  localparam logic [3:0] OpOr    = 4'd7;
  localparam logic [3:0] OpXor   = 4'd8;
  localparam logic [3:0] OpNot   = 4'd9;
  localparam logic [3:0] OpMul   = 4'd10;
  localparam logic [3:0] OpLsh   = 4'd11;
  localparam logic [3:0] OpRsh   = 4'd12;
  localparam logic [3:0] OpArsh  = 4'd13;

  typedef enum logic [3:0] {
    CondEq = 4'd0,
    CondNe = 4'd1,
    CondCs = 4'd2,
    CondCc = 4'd3,
    CondHi = 4'd4,
    CondLs = 4'd5,
    CondGt = 4'd6,
    CondLe = 4'd7,
    CondFs = 4'd8,
    CondFc = 4'd9,
    CondLo = 4'd10,
    CondHs = 4'd11,
    CondLt = 4'd12,
    CondGe = 4'd13,
    CondUc = 4'd14,
    CondNv = 4'd15
  } cond_e;

  // Which flag bits an opcode is allowed to write.
  function automatic logic [FlagW-1:0] update_mask(input logic [3:0] op);
    logic [FlagW-1:0] mask;
    mask = '0;
    if (op <= OpSubu) begin
      mask = '1;
    end else if (op <= OpArsh) begin
      mask[FlagZ] = 1'b1;
      mask[FlagN] = 1'b1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/cr16_cond_eval.sv
// Combinational CR16 condition evaluation against the architectural flags.
module cr16_cond_eval
  import cr16_psr_pkg::*;
(
  input  logic [FlagW-1:0] flags_i,
  input  logic [3:0]       cond_i,
  output logic             true_o
);

  logic c, l, f, z, n;

  assign c = flags_i[FlagC];
  assign l = flags_i[FlagL];
  assign f = flags_i[FlagF];
  assign z = flags_i[FlagZ];
  assign n = flags_i[FlagN];

  always_comb begin
    true_o = 1'b0;
    unique case (cond_e'(cond_i))
      CondEq: true_o = z;
      CondNe: true_o = !z;
      CondCs: true_o = c;
      CondCc: true_o = !c;
      CondHi: true_o = l;
      CondLs: true_o = !l;
      CondGt: true_o = n;
      CondLe: true_o = !n;
      CondFs: true_o = f;
      CondFc: true_o = !f;
      CondLo: true_o = !l && !z;
      CondHs: true_o = l || z;
      CondLt: true_o = !n && !z;
      CondGe: true_o = n || z;
      CondUc: true_o = 1'b1;
      CondNv: true_o = 1'b0;
      default: true_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/cr16_psr.sv
// CR16 processor status register: masked flag capture from the ALU, condition
// evaluation, and a LIFO shadow stack for saving flags around calls/interrupts.
module cr16_psr
  import cr16_psr_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned DepthW = $clog2(DEPTH + 1)
) (
  input  logic              I_CLK,
  input  logic              I_NRESET,
  input  logic              I_ENABLE,
  input  logic [3:0]        I_OPCODE,
  input  logic [FlagW-1:0]  I_STATUS,
  input  logic              I_UPDATE,
  input  logic [3:0]        I_COND,
  input  logic              I_SAVE,
  input  logic              I_RESTORE,
  input  logic              I_CLEAR_ERR,
  output logic [FlagW-1:0]  O_FLAGS,
  output logic              O_COND_TRUE,
  output logic [DepthW-1:0] O_DEPTH,
  output logic              O_FULL,
  output logic              O_EMPTY,
  output logic              O_ERR
);

  logic [FlagW-1:0]  flags_q, flags_d;
  logic [DepthW-1:0] depth_q, depth_d;
  logic              err_q, err_d;
  logic [FlagW-1:0]  stack_q [DEPTH];
  logic [FlagW-1:0]  top_flags;
  logic [FlagW-1:0]  mask;

  logic full, empty;
  logic push_req, pop_req, push_ok, pop_ok, err_set;

  assign full  = (depth_q == DepthW'(DEPTH));
  assign empty = (depth_q == '0);

  assign push_req = I_ENABLE && I_SAVE;
  assign pop_req  = I_ENABLE && I_RESTORE;

  // Simultaneous save and restore is ambiguous; drop both and flag it.
  assign push_ok = push_req && !pop_req && !full;
  assign pop_ok  = pop_req && !push_req && !empty;
  assign err_set = (push_req && pop_req) ||
                   (push_req && full) ||
                   (pop_req && empty);

  assign mask = update_mask(I_OPCODE);

  always_comb begin
    top_flags = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (depth_q == DepthW'(i + 1)) begin
        top_flags = stack_q[i];
      end
    end
  end

  always_comb begin
    flags_d = flags_q;
    if (pop_ok) begin
      flags_d = top_flags;
    end else if (I_ENABLE && I_UPDATE) begin
      flags_d = (I_STATUS & mask) | (flags_q & ~mask);
    end
  end

  always_comb begin
    depth_d = depth_q;
    if (push_ok) begin
      depth_d = depth_q + DepthW'(1);
    end else if (pop_ok) begin
      depth_d = depth_q - DepthW'(1);
    end
  end

  always_comb begin
    err_d = err_q;
    if (err_set) begin
      err_d = 1'b1;
    end else if (I_ENABLE && I_CLEAR_ERR) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      flags_q <= '0;
      depth_q <= '0;
      err_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      depth_q <= depth_d;
      err_q   <= err_d;
    end
  end

  // Stack contents need no reset; only the depth counter qualifies them.
  always_ff @(posedge I_CLK) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (push_ok && (depth_q == DepthW'(i))) begin
        stack_q[i] <= flags_q;
      end
    end
  end

  cr16_cond_eval u_cond_eval (
    .flags_i (flags_q),
    .cond_i  (I_COND),
    .true_o  (O_COND_TRUE)
  );

  assign O_FLAGS = flags_q;
  assign O_DEPTH = depth_q;
  assign O_FULL  = full;
  assign O_EMPTY = empty;
  assign O_ERR   = err_q;

endmodule
